// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the round-robin arbiter and the FIFO write port.
// The requester/FIFO side uses the master modport; the arbiter uses the slave modport.
interface fifo_wr_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = 2
);
  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] data_i;
  logic                  fifo_full_i;
  logic [NREQ-1:0]       gnt_o;
  logic [NREQ-1:0]       ack_o;
  logic [IDX_WIDTH-1:0]  owner_o;
  logic                  busy_o;
  logic                  fifo_wr_en_o;
  logic [WIDTH-1:0]      fifo_wdata_o;

  modport master (
    output req_i, data_i, fifo_full_i,
    input  gnt_o, ack_o, owner_o, busy_o, fifo_wr_en_o, fifo_wdata_o
  );

  modport slave (
    input  req_i, data_i, fifo_full_i,
    output gnt_o, ack_o, owner_o, busy_o, fifo_wr_en_o, fifo_wdata_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters; every write is gated by full.
// Define FIFO_WR_ARB_BURST_EN to hold a grant for up to BURST_LEN beats; otherwise one beat per grant.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 3,
  parameter int IDX_WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fifo_wr_arbiter_if.slave bus
);
`ifdef FIFO_WR_ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif
  // Count value at which the beat being written is the last one of the grant.
  localparam int LAST_BEAT = BURST_EN ? BURST_LEN - 1 : 0;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] owner_q, owner_d;
  logic [IDX_WIDTH-1:0] last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0] cand, pick;
  logic                 found, owner_req, beat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_WIDTH'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Search starts just after the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    pick  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_WIDTH'((int'(last_q) + i) % NREQ);
      if (!found && bus.req_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign owner_req = bus.req_i[owner_q];
  assign beat      = (state_q == GRANT) && owner_req && !bus.fifo_full_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          owner_d = pick;
          last_d  = pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d = IDLE;
        end else if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_WIDTH'(LAST_BEAT)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low during reset so a burst in flight issues no write.
  always_comb begin
    bus.gnt_o        = '0;
    bus.ack_o        = '0;
    bus.owner_o      = '0;
    bus.busy_o       = 1'b0;
    bus.fifo_wr_en_o = 1'b0;
    bus.fifo_wdata_o = '0;
    if (!rst_i && state_q == GRANT) begin
      bus.gnt_o[owner_q] = 1'b1;
      bus.owner_o        = owner_q;
      bus.busy_o         = 1'b1;
      bus.fifo_wdata_o   = bus.data_i[int'(owner_q)*WIDTH +: WIDTH];
      if (beat) begin
        bus.fifo_wr_en_o   = 1'b1;
        bus.ack_o[owner_q] = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset gating, rotation, full stalls, request drop, reset mid-burst.
// Expected beat counts follow FIFO_WR_ARB_BURST_EN (4-beat bursts when defined, single beats otherwise).
module tb_fifo_wr_arbiter;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam int EB = 4;
`else
  localparam int EB = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   nwr;

  fifo_wr_arbiter_if #(.NREQ(4), .WIDTH(8), .IDX_WIDTH(2)) ifc ();

  fifo_wr_arbiter #(
    .NREQ(4), .WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(3), .IDX_WIDTH(2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " gnt"},   32'(ifc.gnt_o), 32'h0);
    chk({tag, " ack"},   32'(ifc.ack_o), 32'h0);
    chk({tag, " owner"}, 32'(ifc.owner_o), 32'h0);
    chk({tag, " busy"},  32'(ifc.busy_o), 32'h0);
    chk({tag, " wr"},    32'(ifc.fifo_wr_en_o), 32'h0);
    chk({tag, " wdata"}, 32'(ifc.fifo_wdata_o), 32'h0);
  endtask

  task automatic chk_grant(input string tag, input int own, input bit wr);
    chk({tag, " gnt"},   32'(ifc.gnt_o), 32'(1) << own);
    chk({tag, " ack"},   32'(ifc.ack_o), wr ? (32'(1) << own) : 32'h0);
    chk({tag, " owner"}, 32'(ifc.owner_o), 32'(own));
    chk({tag, " busy"},  32'(ifc.busy_o), 32'h1);
    chk({tag, " wr"},    32'(ifc.fifo_wr_en_o), 32'(wr));
    chk({tag, " wdata"}, 32'(ifc.fifo_wdata_o), 32'h0A0 + 32'(own));
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst = 1'b1;
    ifc.req_i = r;
    ifc.fifo_full_i = 1'b0;
    @(negedge clk); chk_idle("rst_a");
    step();
    @(negedge clk); chk_idle("rst_b");
    step();
    rst = 1'b0;
  endtask

  // Continuous requests: each slot is one arbitration cycle followed by EB beats.
  task automatic stream(input string tag, input logic [3:0] r, input int ncyc, input int nown,
                        input int own [4], output int nw);
    nw = 0;
    ifc.req_i = r;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c % (EB + 1) == 0) chk_idle({tag, " arb"});
      else chk_grant({tag, " beat"}, own[(c / (EB + 1)) % nown], 1'b1);
      nw += int'(ifc.fifo_wr_en_o);
      step();
    end
  endtask

  initial begin
    ifc.req_i       = '0;
    ifc.fifo_full_i = 1'b0;
    ifc.data_i      = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    step();

    // reset with all requesting, then full rotation
    do_reset(4'b1111);
    stream("rr4", 4'b1111, 20, 4, '{0, 1, 2, 3}, nwr);
    chk("rr4 writes", 32'(nwr), 32'(20 / (EB + 1) * EB));

    // owner 2 stalled by full for 3 cycles
    do_reset(4'b0000);
    ifc.req_i = 4'b0100;
    nwr = 0;
    @(negedge clk); chk_idle("full arb");
    step();
    if (EB > 1) begin
      @(negedge clk); chk_grant("full pre", 2, 1'b1); nwr += int'(ifc.fifo_wr_en_o);
      step();
    end
    ifc.fifo_full_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk_grant("full stall", 2, 1'b0); nwr += int'(ifc.fifo_wr_en_o);
      step();
    end
    ifc.fifo_full_i = 1'b0;
    for (int k = 0; k < ((EB > 1) ? EB - 1 : EB); k++) begin
      @(negedge clk); chk_grant("full post", 2, 1'b1); nwr += int'(ifc.fifo_wr_en_o);
      step();
    end
    @(negedge clk); chk_idle("full end");
    chk("full writes", 32'(nwr), 32'(EB));
    step();

    // owner 1 drops its request
    do_reset(4'b0000);
    ifc.req_i = 4'b0110;
    @(negedge clk); chk_idle("drop arb");
    step();
    for (int k = 0; k < ((EB >= 3) ? 2 : 0); k++) begin
      @(negedge clk); chk_grant("drop beat", 1, 1'b1);
      step();
    end
    ifc.req_i = 4'b0100;
    @(negedge clk); chk_grant("drop cyc", 1, 1'b0);
    step();
    @(negedge clk); chk_idle("drop idle");
    step();
    @(negedge clk); chk_grant("drop next", 2, 1'b1);
    step();

    // two sparse requesters alternate
    do_reset(4'b0000);
    stream("alt", 4'b0101, 4 * (EB + 1), 2, '{0, 2, 0, 0}, nwr);
    chk("alt writes", 32'(nwr), 32'(4 * EB));

    // reset during the second write of requester 3
    do_reset(4'b0000);
    ifc.req_i = 4'b1000;
    @(negedge clk); chk_idle("mid arb");
    step();
    @(negedge clk); chk_grant("mid beat1", 3, 1'b1);
    step();
    if (EB == 1) begin
      @(negedge clk); chk_idle("mid arb2");
      step();
    end
    rst = 1'b1;
    ifc.req_i = 4'b1001;
    @(negedge clk); chk_idle("mid rst");
    step();
    rst = 1'b0;
    @(negedge clk); chk_idle("mid post");
    step();
    @(negedge clk); chk_grant("mid prio", 0, 1'b1);
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
